// File: rtl/snn_pkg.sv
// Shared types, widths and helpers for the spike fibre encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// enc_state_t : encoder frame state (COLLECT neurons / EMIT descriptor)
// IDX_W/NNZ_W : neuron index and nonzero-count widths for the default frame size
// popcount    : set-bit count of a spike vector, zero-extended to 32 bits by the caller
package snn_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } enc_state_t;

  localparam int BITMASK_WIDTH_DEF = 128;
  localparam int TIMESTEPS_DEF     = 8;
  localparam int IDX_W             = $clog2(BITMASK_WIDTH_DEF);
  // One extra bit so a fully dense frame (count == width) is representable.
  localparam int NNZ_W             = IDX_W + 1;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/fibre_bank_ctrl.sv
// Fibre memory bank select and write-address formation.
// Latency: address is combinational from the bank register and index; bank flips 1 cycle after i_toggle.
// Backpressure: none; the toggle is only pulsed on the descriptor handshake.
//
// Ports: clk, rst_n (async active-low), i_toggle (flip bank), i_idx (slot in bank),
//        o_bank (current bank), o_addr ({bank, idx} zero-extended to ADDR_WIDTH).
module fibre_bank_ctrl
  import snn_pkg::*;
#(
  parameter int IDXW       = IDX_W,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_toggle,
  input  logic [IDXW-1:0]       i_idx,
  output logic                  o_bank,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  logic r_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= 1'b0;
    end else if (i_toggle) begin
      r_bank <= ~r_bank;
    end
  end

  assign o_bank = r_bank;
  assign o_addr = ADDR_WIDTH'({r_bank, i_idx});

endmodule

// File: rtl/spike_fibre_encoder.sv
// Compresses a frame of per-neuron spike vectors into an activation bitmask plus packed fibre writes.
// Latency: fibre write 1 cycle after accept; descriptor valid 1 cycle after the last neuron is accepted.
// Backpressure: spike_ready drops while a descriptor waits for out_ready; returns the cycle after handshake.
//
// Ports: spike_in/spike_valid/spike_last/spike_ready  - neuron stream from the LIF stage
//        fibre_wr_en/fibre_wr_addr/fibre_wr_data       - fibre memory write port ({bank, slot})
//        bitmask_out/nnz_count/out_bank/out_valid/out_ready - frame descriptor handshake
// Optional: define SPIKE_ENC_STATS_EN to add total_spikes (sum of set bits over the frame).
module spike_fibre_encoder
  import snn_pkg::*;
#(
  parameter int BITMASK_WIDTH = BITMASK_WIDTH_DEF,
  parameter int TIMESTEPS     = TIMESTEPS_DEF,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [TIMESTEPS-1:0]               spike_in,
  input  logic                               spike_valid,
  input  logic                               spike_last,
  output logic                               spike_ready,
  output logic                               fibre_wr_en,
  output logic [ADDR_WIDTH-1:0]              fibre_wr_addr,
  output logic [TIMESTEPS-1:0]               fibre_wr_data,
  output logic [BITMASK_WIDTH-1:0]           bitmask_out,
  output logic [$clog2(BITMASK_WIDTH):0]     nnz_count,
`ifdef SPIKE_ENC_STATS_EN
  output logic [$clog2(BITMASK_WIDTH*TIMESTEPS):0] total_spikes,
`endif
  output logic                               out_bank,
  output logic                               out_valid,
  input  logic                               out_ready
);

  localparam int IW = $clog2(BITMASK_WIDTH);
  localparam int NW = IW + 1;
`ifdef SPIKE_ENC_STATS_EN
  localparam int TW = $clog2(BITMASK_WIDTH*TIMESTEPS) + 1;
`endif

  enc_state_t                r_state;
  logic [IW-1:0]             r_idx;
  logic [NW-1:0]             r_nnz;
  logic [BITMASK_WIDTH-1:0]  r_bitmask;
  logic                      r_wr_en;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic [TIMESTEPS-1:0]      r_wr_data;
  logic                      r_out_valid;
`ifdef SPIKE_ENC_STATS_EN
  logic [TW-1:0]             r_total;
`endif

  logic                      w_accept;
  logic                      w_nonzero;
  logic                      w_frame_end;
  logic                      w_handshake;
  logic                      w_bank;
  logic [ADDR_WIDTH-1:0]     w_bank_addr;

  assign w_accept    = spike_valid && (r_state == COLLECT);
  assign w_nonzero   = |spike_in;
  // A frame closes on the last physical neuron or an early spike_last, whichever comes first.
  assign w_frame_end = (r_idx == IW'(BITMASK_WIDTH - 1)) || spike_last;
  assign w_handshake = r_out_valid && out_ready;

  // Slot within the bank is the running nonzero count; it never exceeds width-1 at write time.
  fibre_bank_ctrl #(
    .IDXW       (IW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_toggle (w_handshake),
    .i_idx    (r_nnz[IW-1:0]),
    .o_bank   (w_bank),
    .o_addr   (w_bank_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_idx       <= '0;
      r_nnz       <= '0;
      r_bitmask   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_out_valid <= 1'b0;
`ifdef SPIKE_ENC_STATS_EN
      r_total     <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_bitmask[r_idx] <= w_nonzero;
            if (w_nonzero) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_bank_addr;
              r_wr_data <= spike_in;
              r_nnz     <= r_nnz + NW'(1);
            end
`ifdef SPIKE_ENC_STATS_EN
            // popcount works on 32 bits; TIMESTEPS is assumed to be at most 32.
            r_total <= r_total + TW'(popcount(32'(spike_in)));
`endif
            r_idx <= r_idx + IW'(1);
            if (w_frame_end) begin
              r_state     <= EMIT;
              r_out_valid <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (w_handshake) begin
            r_state     <= COLLECT;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_nnz       <= '0;
            r_bitmask   <= '0;
`ifdef SPIKE_ENC_STATS_EN
            r_total     <= '0;
`endif
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign spike_ready   = (r_state == COLLECT);
  assign fibre_wr_en   = r_wr_en;
  assign fibre_wr_addr = r_wr_addr;
  assign fibre_wr_data = r_wr_data;
  assign bitmask_out   = r_bitmask;
  assign nnz_count     = r_nnz;
  assign out_bank      = w_bank;
  assign out_valid     = r_out_valid;
`ifdef SPIKE_ENC_STATS_EN
  assign total_spikes  = r_total;
`endif

endmodule

// File: tb/tb_spike_fibre_encoder.sv
module tb_spike_fibre_encoder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   spike_in;
  logic         spike_valid;
  logic         spike_last;
  logic         spike_ready;
  logic         fibre_wr_en;
  logic [7:0]   fibre_wr_addr;
  logic [7:0]   fibre_wr_data;
  logic [127:0] bitmask_out;
  logic [7:0]   nnz_count;
  logic         out_bank;
  logic         out_valid;
  logic         out_ready;

  int total = 0;
  int bad   = 0;

  logic [7:0] wq_addr[$];
  logic [7:0] wq_data[$];

  spike_fibre_encoder #(
    .BITMASK_WIDTH (128),
    .TIMESTEPS     (8),
    .ADDR_WIDTH    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spike_in      (spike_in),
    .spike_valid   (spike_valid),
    .spike_last    (spike_last),
    .spike_ready   (spike_ready),
    .fibre_wr_en   (fibre_wr_en),
    .fibre_wr_addr (fibre_wr_addr),
    .fibre_wr_data (fibre_wr_data),
    .bitmask_out   (bitmask_out),
    .nnz_count     (nnz_count),
    .out_bank      (out_bank),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  // Record every fibre write, sampled mid-cycle.
  always @(negedge clk) begin
    if (fibre_wr_en === 1'b1) begin
      wq_addr.push_back(fibre_wr_addr);
      wq_data.push_back(fibre_wr_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic last);
    int n;
    n = 0;
    spike_in    = v;
    spike_valid = 1'b1;
    spike_last  = last;
    while (spike_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (spike_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout: spike_ready=%b required 1", spike_ready);
    end
    step();
    spike_valid = 1'b0;
    spike_last  = 1'b0;
    spike_in    = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; spike_valid = 1'b0; spike_last = 1'b0; spike_in = 8'h00;
    repeat (2) step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (fibre_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", fibre_wr_en); end
    total++; if (nnz_count !== 8'd0) begin bad++; $display("FAIL rst_nnz: got %0d want 0", nnz_count); end
    total++; if (bitmask_out !== 128'd0) begin bad++; $display("FAIL rst_bitmask: got %h want 0", bitmask_out); end
    total++; if (out_bank !== 1'b0) begin bad++; $display("FAIL rst_bank: got %b want 0", out_bank); end
    rst_n = 1'b1;
    step();
    total++; if (spike_ready !== 1'b1) begin bad++; $display("FAIL rst_spike_ready: got %b want 1", spike_ready); end
  endtask

  task automatic test_dense();
    logic [127:0] exp_bm;
    int errs;
    exp_bm = '1;
    errs = 0;
    wq_addr.delete(); wq_data.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 128; i++) send(8'h01, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dense_out_valid: got %b want 1", out_valid); end
    total++; if (spike_ready !== 1'b0) begin bad++; $display("FAIL dense_spike_ready: got %b want 0", spike_ready); end
    total++; if (nnz_count !== 8'd128) begin bad++; $display("FAIL dense_nnz: got %0d want 128", nnz_count); end
    total++; if (bitmask_out !== exp_bm) begin bad++; $display("FAIL dense_bitmask: got %h want %h", bitmask_out, exp_bm); end
    total++; if (out_bank !== 1'b0) begin bad++; $display("FAIL dense_bank: got %b want 0", out_bank); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dense_hs_valid: got %b want 0", out_valid); end
    total++; if (spike_ready !== 1'b1) begin bad++; $display("FAIL dense_hs_ready: got %b want 1", spike_ready); end
    total++; if (out_bank !== 1'b1) begin bad++; $display("FAIL dense_bank_toggle: got %b want 1", out_bank); end
    total++; if (wq_addr.size() !== 128) begin bad++; $display("FAIL dense_wr_count: got %0d want 128", wq_addr.size()); end
    for (int i = 0; i < wq_addr.size(); i++)
      if (wq_addr[i] !== 8'(i) || wq_data[i] !== 8'h01) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL dense_wr_content: got %0d bad writes want 0", errs); end
  endtask

  task automatic test_zero_frame();
    wq_addr.delete(); wq_data.delete();
    out_ready = 1'b1;
    send(8'h00, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_out_valid: got %b want 1", out_valid); end
    total++; if (nnz_count !== 8'd0) begin bad++; $display("FAIL zero_nnz: got %0d want 0", nnz_count); end
    total++; if (bitmask_out !== 128'd0) begin bad++; $display("FAIL zero_bitmask: got %h want 0", bitmask_out); end
    total++; if (out_bank !== 1'b1) begin bad++; $display("FAIL zero_bank: got %b want 1", out_bank); end
    step();
    total++; if (wq_addr.size() !== 0) begin bad++; $display("FAIL zero_wr_count: got %0d want 0", wq_addr.size()); end
    total++; if (out_bank !== 1'b0) begin bad++; $display("FAIL zero_bank_wrap: got %b want 0", out_bank); end
  endtask

  task automatic test_short_backpressure();
    logic [7:0] vec[5];
    logic [7:0] exp_d[4];
    int errs;
    vec   = '{8'h11, 8'h00, 8'h22, 8'h33, 8'h44};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    errs = 0;
    wq_addr.delete(); wq_data.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(vec[i], i == 4);
    total++; if (bitmask_out !== 128'h1D) begin bad++; $display("FAIL short_bitmask: got %h want 1d", bitmask_out); end
    total++; if (out_bank !== 1'b0) begin bad++; $display("FAIL short_bank: got %b want 0", out_bank); end
    // Keep pushing while the descriptor is stalled; nothing may be accepted.
    spike_valid = 1'b1; spike_in = 8'hEE;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid !== 1'b1 || spike_ready !== 1'b0 || nnz_count !== 8'd4) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL short_hold: got %0d bad cycles want 0", errs); end
    spike_valid = 1'b0; spike_in = 8'h00; out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL short_hs_valid: got %b want 0", out_valid); end
    total++; if (spike_ready !== 1'b1) begin bad++; $display("FAIL short_hs_ready: got %b want 1", spike_ready); end
    total++; if (out_bank !== 1'b1) begin bad++; $display("FAIL short_bank_toggle: got %b want 1", out_bank); end
    total++; if (wq_addr.size() !== 4) begin bad++; $display("FAIL short_wr_count: got %0d want 4", wq_addr.size()); end
    errs = 0;
    for (int i = 0; i < 4 && i < wq_addr.size(); i++)
      if (wq_addr[i] !== 8'(i) || wq_data[i] !== exp_d[i]) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL short_wr_content: got %0d bad writes want 0", errs); end
  endtask

  task automatic test_sparse();
    logic [127:0] exp_bm;
    logic [7:0]   v;
    exp_bm = '0;
    exp_bm[3] = 1'b1;
    exp_bm[100] = 1'b1;
    wq_addr.delete(); wq_data.delete();
    out_ready = 1'b1;
    // spike_last also asserted on the 128th neuron: must behave as a normal frame end.
    for (int i = 0; i < 128; i++) begin
      v = (i == 3) ? 8'hA5 : ((i == 100) ? 8'h10 : 8'h00);
      send(v, i == 127);
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sparse_out_valid: got %b want 1", out_valid); end
    total++; if (nnz_count !== 8'd2) begin bad++; $display("FAIL sparse_nnz: got %0d want 2", nnz_count); end
    total++; if (bitmask_out !== exp_bm) begin bad++; $display("FAIL sparse_bitmask: got %h want %h", bitmask_out, exp_bm); end
    total++; if (out_bank !== 1'b1) begin bad++; $display("FAIL sparse_bank: got %b want 1", out_bank); end
    step();
    total++; if (wq_addr.size() !== 2) begin bad++; $display("FAIL sparse_wr_count: got %0d want 2", wq_addr.size()); end
    if (wq_addr.size() == 2) begin
      total++; if (wq_addr[0] !== 8'd128 || wq_data[0] !== 8'hA5) begin bad++; $display("FAIL sparse_wr0: got %0d:%h want 128:a5", wq_addr[0], wq_data[0]); end
      total++; if (wq_addr[1] !== 8'd129 || wq_data[1] !== 8'h10) begin bad++; $display("FAIL sparse_wr1: got %0d:%h want 129:10", wq_addr[1], wq_data[1]); end
    end
    total++; if (out_bank !== 1'b0) begin bad++; $display("FAIL sparse_bank_wrap: got %b want 0", out_bank); end
  endtask

  task automatic test_mid_reset();
    wq_addr.delete(); wq_data.delete();
    out_ready = 1'b1;
    send(8'h5A, 1'b1);
    total++; if (nnz_count !== 8'd1 || bitmask_out !== 128'd1) begin bad++; $display("FAIL one_neuron: got nnz=%0d bm=%h want 1/1", nnz_count, bitmask_out); end
    step();
    total++; if (out_bank !== 1'b1) begin bad++; $display("FAIL one_neuron_bank: got %b want 1", out_bank); end
    for (int i = 0; i < 60; i++) send(8'h03, 1'b0);
    rst_n = 1'b0;
    #1;
    total++; if (fibre_wr_en !== 1'b0) begin bad++; $display("FAIL mrst_wr_en: got %b want 0", fibre_wr_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid: got %b want 0", out_valid); end
    total++; if (nnz_count !== 8'd0 || bitmask_out !== 128'd0) begin bad++; $display("FAIL mrst_state: got nnz=%0d bm=%h want 0/0", nnz_count, bitmask_out); end
    total++; if (out_bank !== 1'b0) begin bad++; $display("FAIL mrst_bank: got %b want 0", out_bank); end
    step();
    rst_n = 1'b1;
    step();
    wq_addr.delete(); wq_data.delete();
    send(8'h77, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_rst_valid: got %b want 1", out_valid); end
    total++; if (bitmask_out !== 128'd1 || nnz_count !== 8'd1) begin bad++; $display("FAIL post_rst_frame: got bm=%h nnz=%0d want 1/1", bitmask_out, nnz_count); end
    total++; if (out_bank !== 1'b0) begin bad++; $display("FAIL post_rst_bank: got %b want 0", out_bank); end
    step();
    total++; if (wq_addr.size() !== 1) begin bad++; $display("FAIL post_rst_wr_count: got %0d want 1", wq_addr.size()); end
    if (wq_addr.size() == 1) begin
      total++; if (wq_addr[0] !== 8'd0 || wq_data[0] !== 8'h77) begin bad++; $display("FAIL post_rst_wr: got %0d:%h want 0:77", wq_addr[0], wq_data[0]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dense();
    test_zero_frame();
    test_short_backpressure();
    test_sparse();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
